// File: rtl/hist_seq_ctrl.sv
// rtl/hist_seq_ctrl.sv - register file and frame sequencer for the histogram core
//
// Purpose:
//   Decodes write/read strobes from the AXI-Lite front-end into the CTRL,
//   FRAME_LEN and STATUS registers. Steps the histogram datapath through
//   bin clear, pixel accumulation and pipeline flush. Raises done/irq once
//   the histogram of a frame is complete.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en            write strobe; awaddr/wdata/wstrb sampled with it
//   rd_en            read strobe; araddr sampled with it
//   rdata            registered read data, valid the cycle after rd_en
//   clr_en/clr_addr  datapath bin clear (write zero to bin clr_addr)
//   hist_en          datapath accumulation enable
//   pix_accept       one pixel accepted by the datapath this cycle
//   busy             sequencer not idle
//   irq              one-cycle pulse on frame completion

module hist_seq_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int BIN_BITS   = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic [31:0]           rdata,
  output logic                  clr_en,
  output logic [BIN_BITS-1:0]   clr_addr,
  output logic                  hist_en,
  input  logic                  pix_accept,
  output logic                  busy,
  output logic                  irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(4'h0);
  localparam logic [ADDR_WIDTH-1:0] A_LEN    = ADDR_WIDTH'(4'h4);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(4'h8);

  localparam int FW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  // FLUSH lasts PIPE_DEPTH cycles: load PIPE_DEPTH-1 and leave on zero.
  localparam logic [FW-1:0]       FLUSH_LOAD = FW'(PIPE_DEPTH - 1);
  localparam logic [BIN_BITS-1:0] CLR_LAST   = '1;

  logic [1:0]          state_q, state_d;
  logic [31:0]         frame_len_q, frame_len_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         pix_cnt_q, pix_cnt_d;
  logic [BIN_BITS-1:0] clr_addr_q, clr_addr_d;
  logic                clr_en_q, clr_en_d;
  logic                hist_en_q, hist_en_d;
  logic                irq_q, irq_d;
  logic                done_q, done_d;
  logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [31:0]         rdata_q, rdata_d;

  logic wr_ctrl, start_req, abort_req, len_wr, w1c_done, last_pix;

  // ABORT has priority over START when both bits arrive in one write.
  assign wr_ctrl   = wr_en && (awaddr == A_CTRL) && wstrb[0];
  assign start_req = wr_ctrl && wdata[0] && !wdata[1];
  assign abort_req = wr_ctrl && wdata[1];
  assign len_wr    = wr_en && (awaddr == A_LEN) && (state_q == S_IDLE);
  assign w1c_done  = wr_en && (awaddr == A_STATUS) && wstrb[0] && wdata[0];
  // len_q is never zero in RUN, so len_q-1 cannot underflow there.
  assign last_pix  = pix_accept && (pix_cnt_q == len_q - 32'd1);

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    len_d       = len_q;
    pix_cnt_d   = pix_cnt_q;
    clr_addr_d  = clr_addr_q;
    clr_en_d    = clr_en_q;
    hist_en_d   = hist_en_q;
    irq_d       = 1'b0;
    done_d      = done_q;
    flush_cnt_d = flush_cnt_q;
    rdata_d     = rdata_q;

    for (int b = 0; b < 4; b++) begin
      if (len_wr && wstrb[b]) begin
        frame_len_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end

    // Clear first so a same-cycle completion below overrides it.
    if (w1c_done) begin
      done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d    = S_CLEAR;
          len_d      = frame_len_q;
          pix_cnt_d  = 32'd0;
          clr_addr_d = '0;
          clr_en_d   = 1'b1;
          done_d     = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clr_addr_q == CLR_LAST) begin
          clr_en_d = 1'b0;
          if (len_q == 32'd0) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d   = S_RUN;
            hist_en_d = 1'b1;
          end
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_RUN: begin
        if (pix_accept) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
        end
        if (last_pix) begin
          state_d     = S_FLUSH;
          hist_en_d   = 1'b0;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          irq_d   = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
    endcase

    // Abort leaves done as it was and suppresses any completion pulse.
    if (abort_req && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      clr_en_d  = 1'b0;
      hist_en_d = 1'b0;
      irq_d     = 1'b0;
      done_d    = done_q;
    end

    if (rd_en) begin
      if (araddr == A_LEN) begin
        rdata_d = frame_len_q;
      end else if (araddr == A_STATUS) begin
        rdata_d = {pix_cnt_q[23:0], 5'b0, state_q, done_q};
      end else begin
        rdata_d = 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_len_q <= 32'd0;
      len_q       <= 32'd0;
      pix_cnt_q   <= 32'd0;
      clr_addr_q  <= '0;
      clr_en_q    <= 1'b0;
      hist_en_q   <= 1'b0;
      irq_q       <= 1'b0;
      done_q      <= 1'b0;
      flush_cnt_q <= '0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      len_q       <= len_d;
      pix_cnt_q   <= pix_cnt_d;
      clr_addr_q  <= clr_addr_d;
      clr_en_q    <= clr_en_d;
      hist_en_q   <= hist_en_d;
      irq_q       <= irq_d;
      done_q      <= done_d;
      flush_cnt_q <= flush_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata    = rdata_q;
  assign clr_en   = clr_en_q;
  assign clr_addr = clr_addr_q;
  assign hist_en  = hist_en_q;
  assign irq      = irq_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_hist_seq_ctrl.sv
// tb/tb_hist_seq_ctrl.sv - directed and randomized bench for hist_seq_ctrl

module tb_hist_seq_ctrl;

  localparam int NBINS = 256;
  localparam int PD    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  araddr = '0;
  logic [31:0] rdata;
  logic        clr_en;
  logic [7:0]  clr_addr;
  logic        hist_en;
  logic        pix_accept = 1'b0;
  logic        busy;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Software view of the register block.
  logic [31:0] m_len  = 32'd0;
  logic        m_done = 1'b0;

  always #5 clk = ~clk;

  hist_seq_ctrl #(.ADDR_WIDTH(4), .BIN_BITS(8), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .awaddr(awaddr), .wdata(wdata),
    .wstrb(wstrb), .rd_en(rd_en), .araddr(araddr), .rdata(rdata),
    .clr_en(clr_en), .clr_addr(clr_addr), .hist_en(hist_en),
    .pix_accept(pix_accept), .busy(busy), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; awaddr = a; wdata = d; wstrb = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    rd_en = 1'b1; araddr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  function automatic logic [31:0] status_exp(input logic [31:0] pix, input logic [1:0] st,
                                             input logic d);
    return {pix[23:0], 5'b0, st, d};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One frame from START to completion or abort, checking every cycle.
  task automatic run_frame(input int abort_after, input bit busy_poke, input bit w1c_collide);
    logic [31:0] flen;
    logic [31:0] d;
    int acc;
    int cyc;
    bit aborted;
    flen = m_len;
    wr(4'h0, 32'd1, 4'h1);
    m_done = 1'b0;
    for (int i = 0; i < NBINS; i++) begin
      pix_accept = 1'($urandom % 2);
      if (busy_poke && i == 10) begin
        wr_en = 1'b1; awaddr = 4'h4; wdata = ~m_len; wstrb = 4'hF;
      end
      if (busy_poke && i == 11) begin
        wr_en = 1'b1; awaddr = 4'h0; wdata = 32'd1; wstrb = 4'h1;
      end
      if (i == 3) begin
        rd_en = 1'b1; araddr = 4'h8;
      end
      if (i == 4) check("clear_status", rdata, status_exp(32'd0, 2'd1, 1'b0));
      check("clr_en", 32'(clr_en), 32'd1);
      check("clr_addr", 32'(clr_addr), 32'(i));
      check("clear_hist_en", 32'(hist_en), 32'd0);
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    check("clr_en_drop", 32'(clr_en), 32'd0);
    acc = 0;
    cyc = 0;
    aborted = 1'b0;
    while (acc < int'(flen) && cyc < 4000) begin
      if (abort_after >= 0 && acc == abort_after) begin
        pix_accept = 1'b0;
        wr(4'h0, 32'd2, 4'h1);
        aborted = 1'b1;
        break;
      end
      pix_accept = 1'($urandom % 2);
      check("run_hist_en", 32'(hist_en), 32'd1);
      check("run_busy", 32'(busy), 32'd1);
      tick();
      if (pix_accept) acc++;
      cyc++;
    end
    if (aborted) begin
      for (int k = 0; k < 4; k++) begin
        pix_accept = 1'($urandom % 2);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hist_en", 32'(hist_en), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        tick();
      end
      pix_accept = 1'b0;
      rd(4'h8, d);
      check("abort_status", d, status_exp(32'(abort_after), 2'd0, m_done));
      return;
    end
    check("run_pixels", 32'(acc), flen);
    for (int k = 0; k < PD; k++) begin
      pix_accept = 1'($urandom % 2);
      if (w1c_collide && k == PD - 1) begin
        wr_en = 1'b1; awaddr = 4'h8; wdata = 32'd1; wstrb = 4'h1;
      end
      check("flush_hist_en", 32'(hist_en), 32'd0);
      check("flush_irq", 32'(irq), 32'd0);
      check("flush_busy", 32'(busy), 32'd1);
      tick();
      wr_en = 1'b0;
    end
    pix_accept = 1'b0;
    m_done = 1'b1;
    check("irq_pulse", 32'(irq), 32'd1);
    check("done_idle", 32'(busy), 32'd0);
    tick();
    check("irq_one_cycle", 32'(irq), 32'd0);
    rd(4'h8, d);
    check("done_status", d, status_exp(flen, 2'd0, m_done));
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] v;
    logic [3:0]  s;

    // Reset state
    tick();
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr_en", 32'(clr_en), 32'd0);
    check("rst_clr_addr", 32'(clr_addr), 32'd0);
    check("rst_hist_en", 32'(hist_en), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick();
    rd(4'h4, d); check("rst_frame_len", d, 32'd0);
    rd(4'h8, d); check("rst_status", d, 32'd0);

    // 16-pixel frame
    wr(4'h4, 32'd16, 4'hF); m_len = 32'd16;
    run_frame(-1, 1'b0, 1'b0);

    // Zero-length frame skips RUN
    wr(4'h4, 32'd0, 4'hF); m_len = 32'd0;
    run_frame(-1, 1'b0, 1'b0);

    // Abort during RUN after 5 pixels
    v = 32'(20 + $urandom_range(0, 9));
    wr(4'h4, v, 4'hF); m_len = v;
    run_frame(5, 1'b0, 1'b0);

    // FRAME_LEN write and START while busy are ignored
    v = 32'($urandom_range(1, 12));
    wr(4'h4, v, 4'hF); m_len = v;
    run_frame(-1, 1'b1, 1'b0);
    rd(4'h4, d); check("busy_len_kept", d, m_len);

    // Byte strobes on FRAME_LEN
    wr(4'h4, 32'h1234_5678, 4'hF); m_len = 32'h1234_5678;
    wr(4'h4, 32'h0000_AB00, 4'b0010); m_len = merge(m_len, 32'h0000_AB00, 4'b0010);
    rd(4'h4, d); check("strobe_0x1234AB78", d, 32'h1234_AB78);
    for (int n = 0; n < 6; n++) begin
      v = $urandom;
      s = 4'($urandom);
      wr(4'h4, v, s); m_len = merge(m_len, v, s);
      rd(4'h4, d); check("strobe_rand", d, m_len);
    end

    // CTRL without wstrb[0], and START+ABORT in IDLE, do nothing
    wr(4'h0, 32'd1, 4'b1110);
    check("ctrl_nostrb", 32'(busy), 32'd0);
    tick();
    check("ctrl_nostrb2", 32'(busy), 32'd0);
    wr(4'h0, 32'd3, 4'h1);
    check("start_abort_idle", 32'(busy), 32'd0);

    // Unmapped reads, CTRL read, rdata hold
    rd(4'hC, d); check("read_0xC", d, 32'd0);
    rd(4'h0, d); check("read_ctrl", d, 32'd0);
    rd(4'h4, d); check("read_len", d, m_len);
    tick();
    check("rdata_hold", rdata, m_len);

    // W1C of done
    wr(4'h8, 32'd1, 4'b1110);
    rd(4'h8, d); check("w1c_nostrb", 32'(d[0]), 32'(m_done));
    wr(4'h8, 32'd1, 4'h1); m_done = 1'b0;
    rd(4'h8, d); check("w1c_done", 32'(d[0]), 32'd0);

    // W1C colliding with completion: completion wins
    wr(4'h4, 32'd3, 4'hF); m_len = 32'd3;
    run_frame(-1, 1'b0, 1'b1);

    // Async reset mid-CLEAR
    wr(4'h4, 32'd7, 4'hF);
    wr(4'h0, 32'd1, 4'h1);
    for (int n = 0; n < 20; n++) tick();
    check("mid_clear_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_clr_en", 32'(clr_en), 32'd0);
    check("arst_clr_addr", 32'(clr_addr), 32'd0);
    check("arst_hist_en", 32'(hist_en), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_rdata", rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(4'h4, d); check("arst_frame_len", d, 32'd0);
    rd(4'h8, d); check("arst_status", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
